exe_mem_access_ctrl: RTL and testbench
======================================

EXE_MEM_ACCESS_CTRL -- requirements
Module: exe_mem_access_ctrl

Interface
REQ-001 Clocking SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 Pipeline side inputs, sampled from the EXE/MEM register outputs:
- wmem  input  1  store pending
- load_type  input  4  load class: 0000 none, 0001 LW, 0010 LH, 0011 LHU, 0100 LB, 0101 LBU
- store_type  input  4  store class: 0000 none, 0001 SW, 0010 SH, 0100 SB
- addr  input  32  effective address (ALU result)
- wdata  input  32  store data (forwarded rt)
- byte_valid  input  4  byte-lane enables
- exc_block  input  1  instruction carries an exception; suppress access
- flush  input  1  irq or clr
- pipe_adv  input  1  MEM-stage instruction leaves this cycle
REQ-005 Bus side, SRAM-like interface:
- data_req  output  1  request
- data_wr  output  1  1 = write
- data_size  output  2  0 byte, 1 half, 2 word
- data_addr  output  32  address
- data_wstrb  output  4  byte strobes
- data_wdata  output  32  write data
- data_addr_ok  input  1  address accepted
- data_data_ok  input  1  data phase done
- data_rdata  input  32  read data
REQ-006 Pipeline side outputs:
- mem_stall  output  1  MEM busy; drives stall1
- load_result  output  32  extended load data
- load_valid  output  1  load_result valid

Function
REQ-007 access SHALL be defined as (wmem | load_type != 0) & ~exc_block & ~flush.
REQ-008 The FSM SHALL have four states: IDLE, REQ, WAIT, DONE.
- IDLE->REQ on access
- REQ->WAIT on data_addr_ok
- WAIT->DONE on data_data_ok when not cancelled; WAIT->IDLE on data_data_ok when cancelled
- DONE->IDLE on pipe_adv or flush
REQ-009 In IDLE, data_req SHALL be 0; on access, the block SHALL register addr, wdata, byte_valid, load_type, wr and size.
REQ-010 data_req SHALL be 1 exactly while in REQ, and bus outputs SHALL remain stable from REQ entry until data_addr_ok.
REQ-011 mem_stall SHALL equal (IDLE & access) | REQ | WAIT, and SHALL be 0 in DONE.
REQ-012 data_size SHALL be 2 for LW/SW, 1 for LH/LHU/SH, and 0 for LB/LBU/SB.
REQ-013 data_wr SHALL be 1 for stores, and data_wstrb SHALL be byte_valid for stores and 4'b0000 for loads.
REQ-014 data_wdata SHALL be {4{wdata[7:0]}} for SB, {2{wdata[15:0]}} for SH, and wdata for SW.
REQ-015 On data_data_ok for a non-cancelled load, the block SHALL extract data_rdata by registered addr[1:0]:
- LB/LBU: byte lane addr[1:0]
- LH/LHU: halfword lane addr[1]
- LB/LH sign-extend; LBU/LHU zero-extend
- LW: data_rdata unchanged
REQ-016 load_result SHALL be registered, and load_valid SHALL be 1 only in DONE for loads; load_valid SHALL be 0 in DONE for stores.
REQ-017 Fixed latency: access seen in cycle 0 (stall=1), data_req=1 in cycle 1. If data_addr_ok arrives in cycle 1 and data_data_ok in cycle 2, DONE is reached in cycle 3 (stall=0).
REQ-018 data_data_ok SHALL NOT be expected in the same cycle as data_addr_ok; the block SHALL ignore data_data_ok outside WAIT.
REQ-019 A flush in REQ or WAIT SHALL set a cancel flag.
- Request is not withdrawn; the transaction completes on the bus.
- Read data is discarded and load_valid stays 0.
- mem_stall stays 1 until data_data_ok, then the FSM returns to IDLE and clears cancel.
REQ-020 A flush in DONE SHALL return the FSM to IDLE and clear load_valid next cycle.
REQ-021 DONE without pipe_adv SHALL hold, with no reissue.
REQ-022 When pipe_adv and a new access occur together in DONE, the FSM SHALL go to IDLE, then issue the new access from IDLE.

Reset
REQ-023 rst_n=0 SHALL force, at any time including mid-transaction:
- state IDLE, cancel flag 0
- data_req=0, data_wr=0, data_size=0
- data_addr, data_wstrb, data_wdata = 0
- load_result=0, load_valid=0
REQ-024 After reset, no pending bus response SHALL be awaited.

Verification
REQ-025 LB at addr 0x1003, rdata 0x80112233 -> data_size=0, load_result=0xFFFFFF80, load_valid=1 in cycle 3.
REQ-026 SH at addr 0x2002, wdata 0x0000BEEF, byte_valid 1100 -> data_wr=1, data_wdata=0xBEEFBEEF, data_wstrb=1100, mem_stall falls when DONE is reached.
REQ-027 LHU at addr 0x10, data_addr_ok delayed 3 cycles -> data_req held 4 cycles with stable address, rdata 0x0000F00D -> load_result=0x0000F00D.
REQ-028 Flush in WAIT during LW -> mem_stall=1 until data_data_ok, load_valid never 1, FSM in IDLE next cycle.
REQ-029 exc_block=1 with wmem=1 -> data_req stays 0 and mem_stall stays 0.
REQ-030 rst_n low while in WAIT -> all outputs 0 immediately, FSM in IDLE.

Source files
------------

// File: rtl/exe_mem_access_ctrl.sv
// MEM-stage data-bus access controller: turns the EXE/MEM load/store into one
// SRAM-like bus transaction, stalls the pipe while it is in flight, and aligns load data.
module exe_mem_access_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wmem,
    input  logic [3:0]  load_type,
    input  logic [3:0]  store_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  byte_valid,
    input  logic        exc_block,
    input  logic        flush,
    input  logic        pipe_adv,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        mem_stall,
    output logic [31:0] load_result,
    output logic        load_valid
);

    localparam logic [3:0] LT_NONE = 4'b0000;
    localparam logic [3:0] LT_LW   = 4'b0001;
    localparam logic [3:0] LT_LH   = 4'b0010;
    localparam logic [3:0] LT_LHU  = 4'b0011;
    localparam logic [3:0] LT_LB   = 4'b0100;
    localparam logic [3:0] LT_LBU  = 4'b0101;

    localparam logic [3:0] ST_SW   = 4'b0001;
    localparam logic [3:0] ST_SH   = 4'b0010;
    localparam logic [3:0] ST_SB   = 4'b0100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic        cancel_reg;
    logic        cancel_next;
    logic [3:0]  ltype_reg;

    logic        access;
    logic        capture;
    logic        cancelled_now;
    logic        load_done;

    logic [1:0]  size_in;
    logic [31:0] wdata_in;
    logic [31:0] wdata_sb;
    logic [31:0] wdata_sh;

    logic [7:0]  rd_byte [4];
    logic [15:0] rd_half [2];
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_ext;

    assign access  = (wmem | (load_type != LT_NONE)) & ~exc_block & ~flush;
    assign capture = (state_reg == IDLE) & access;

    // A flush arriving together with the data phase still counts as a cancel.
    assign cancelled_now = cancel_reg | flush;
    assign load_done     = (state_reg == WAIT) & data_data_ok & ~cancelled_now
                         & (ltype_reg != LT_NONE);

    // Byte/halfword replication of store data and lane split of read data.
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
        assign wdata_sb[8*gi +: 8] = wdata[7:0];
        assign rd_byte[gi]         = data_rdata[8*gi +: 8];
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_half_lane
        assign wdata_sh[16*gi +: 16] = wdata[15:0];
        assign rd_half[gi]           = data_rdata[16*gi +: 16];
    end

    // Access attributes for the instruction currently presented by EXE/MEM.
    always_comb begin
        size_in  = 2'd0;
        wdata_in = 32'd0;
        if (wmem) begin
            case (store_type)
                ST_SW: begin
                    size_in  = 2'd2;
                    wdata_in = wdata;
                end
                ST_SH: begin
                    size_in  = 2'd1;
                    wdata_in = wdata_sh;
                end
                ST_SB: begin
                    size_in  = 2'd0;
                    wdata_in = wdata_sb;
                end
                default: begin
                    size_in  = 2'd2;
                    wdata_in = wdata;
                end
            endcase
        end else begin
            case (load_type)
                LT_LW:         size_in = 2'd2;
                LT_LH, LT_LHU: size_in = 2'd1;
                default:       size_in = 2'd0;
            endcase
        end
    end

    // Load alignment uses the latched address, not the live pipeline input.
    always_comb begin
        lane_byte = rd_byte[data_addr[1:0]];
        lane_half = rd_half[data_addr[1]];
        load_ext  = data_rdata;
        case (ltype_reg)
            LT_LW:   load_ext = data_rdata;
            LT_LH:   load_ext = {{16{lane_half[15]}}, lane_half};
            LT_LHU:  load_ext = {16'd0, lane_half};
            LT_LB:   load_ext = {{24{lane_byte[7]}}, lane_byte};
            LT_LBU:  load_ext = {24'd0, lane_byte};
            default: load_ext = data_rdata;
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        cancel_next = cancel_reg;
        case (state_reg)
            IDLE: begin
                if (access) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (flush) begin
                    cancel_next = 1'b1;
                end
                if (data_addr_ok) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    cancel_next = 1'b1;
                end
                if (data_data_ok) begin
                    cancel_next = 1'b0;
                    state_next  = cancelled_now ? IDLE : DONE;
                end
            end
            DONE: begin
                if (pipe_adv | flush) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next  = IDLE;
                cancel_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cancel_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cancel_reg <= cancel_next;
        end
    end

    // Bus attributes are latched once at issue and held through the whole transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_wr    <= 1'b0;
            data_size  <= 2'd0;
            data_addr  <= 32'd0;
            data_wstrb <= 4'd0;
            data_wdata <= 32'd0;
            ltype_reg  <= LT_NONE;
        end else if (capture) begin
            data_wr    <= wmem;
            data_size  <= size_in;
            data_addr  <= addr;
            data_wstrb <= wmem ? byte_valid : 4'd0;
            data_wdata <= wdata_in;
            ltype_reg  <= wmem ? LT_NONE : load_type;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_result <= 32'd0;
            load_valid  <= 1'b0;
        end else begin
            if (load_done) begin
                load_result <= load_ext;
            end
            load_valid <= (state_next == DONE) & (ltype_reg != LT_NONE);
        end
    end

    assign data_req = (state_reg == REQ);

    // Gated by rst_n so that a reset asserted mid-cycle drops the stall at once.
    assign mem_stall = rst_n & (capture | (state_reg == REQ) | (state_reg == WAIT));

endmodule

// File: tb/tb_exe_mem_access_ctrl.sv
// Self-checking bench for exe_mem_access_ctrl: directed scenarios plus randomized
// transactions compared against an arithmetic model of sizes, strobes and load extension.
module tb_exe_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wmem = 1'b0;
    logic [3:0]  load_type = 4'd0;
    logic [3:0]  store_type = 4'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [3:0]  byte_valid = 4'd0;
    logic        exc_block = 1'b0;
    logic        flush = 1'b0;
    logic        pipe_adv = 1'b0;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok = 1'b0;
    logic        data_data_ok = 1'b0;
    logic [31:0] data_rdata = 32'd0;
    logic        mem_stall;
    logic [31:0] load_result;
    logic        load_valid;

    int total = 0;
    int bad = 0;
    int txn_id = 0;

    exe_mem_access_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wmem         (wmem),
        .load_type    (load_type),
        .store_type   (store_type),
        .addr         (addr),
        .wdata        (wdata),
        .byte_valid   (byte_valid),
        .exc_block    (exc_block),
        .flush        (flush),
        .pipe_adv     (pipe_adv),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wstrb   (data_wstrb),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_stall    (mem_stall),
        .load_result  (load_result),
        .load_valid   (load_valid)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int nbytes(input bit st, input logic [3:0] typ);
        if (st) return (typ == 4'd1) ? 4 : (typ == 4'd2) ? 2 : 1;
        return (typ == 4'd1) ? 4 : (typ == 4'd2 || typ == 4'd3) ? 2 : 1;
    endfunction

    function automatic logic [1:0] exp_size(input bit st, input logic [3:0] typ);
        int n;
        n = nbytes(st, typ);
        return (n == 4) ? 2'd2 : (n == 2) ? 2'd1 : 2'd0;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [3:0] typ, input logic [31:0] wd);
        int n;
        n = nbytes(1'b1, typ);
        if (n == 4) return wd;
        if (n == 2) return {16'd0, wd[15:0]} * 32'h0001_0001;
        return {24'd0, wd[7:0]} * 32'h0101_0101;
    endfunction

    function automatic logic [31:0] exp_load(input logic [3:0] typ, input logic [31:0] a,
                                             input logic [31:0] rd);
        int n;
        int off;
        bit sgn;
        logic [31:0] v;
        logic [31:0] mask;
        n   = nbytes(1'b0, typ);
        sgn = (typ == 4'd2) || (typ == 4'd4);
        if (n == 4) return rd;
        off  = (n == 2) ? int'(a[1]) * 2 : int'(a[1:0]);
        mask = (32'd1 << (8 * n)) - 32'd1;
        v    = (rd >> (8 * off)) & mask;
        if (sgn && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    // ---------------- transaction driver with inline checks ----------------
    // flush_at: 0 none, 1 first REQ cycle, 2 first WAIT cycle.
    task automatic run_txn(input bit st, input logic [3:0] typ, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] bv, input logic [31:0] rd,
                           input int ok_dly, input int data_dly, input int flush_at,
                           input int hold, input bit end_flush, input bit b2b,
                           input string tag);
        logic [1:0]  esz;
        logic [3:0]  estb;
        logic [31:0] ewd;
        logic [31:0] eres;
        bit wd_bad;
        esz  = exp_size(st, typ);
        estb = st ? bv : 4'd0;
        ewd  = exp_wdata(typ, wd);
        eres = exp_load(typ, a, rd);
        if (flush_at == 2 && data_dly == 0) data_dly = 1;
        txn_id++;
        $display("txn %0d %s: st=%0d type=%0d addr=%h wdata=%h bv=%b rdata=%h okdly=%0d datadly=%0d flush_at=%0d",
                 txn_id, tag, st, typ, a, wd, bv, rd, ok_dly, data_dly, flush_at);

        @(negedge clk);
        pipe_adv = 1'b0; flush = 1'b0; exc_block = 1'b0;
        wmem = st; load_type = st ? 4'd0 : typ; store_type = st ? typ : 4'd0;
        addr = a; wdata = wd; byte_valid = bv;
        #1;
        total++;
        if (mem_stall !== 1'b1 || data_req !== 1'b0 || load_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s issue: stall=%b req=%b lv=%b required stall=1 req=0 lv=0",
                     tag, mem_stall, data_req, load_valid);
        end

        for (int i = 0; i <= ok_dly; i++) begin
            @(negedge clk);
            addr = $urandom; wdata = $urandom;
            flush = (flush_at == 1 && i == 0);
            data_addr_ok = (i == ok_dly);
            data_data_ok = (i != ok_dly) ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            total++;
            wd_bad = st && (data_wdata !== ewd);
            if (data_req !== 1'b1 || mem_stall !== 1'b1 || load_valid !== 1'b0 ||
                data_addr !== a || data_size !== esz || data_wr !== st ||
                data_wstrb !== estb || wd_bad) begin
                bad++;
                $display("FAIL %s req%0d: req=%b stall=%b lv=%b addr=%h size=%0d wr=%b strb=%b wdata=%h required req=1 stall=1 lv=0 addr=%h size=%0d wr=%b strb=%b wdata=%h",
                         tag, i, data_req, mem_stall, load_valid, data_addr, data_size, data_wr,
                         data_wstrb, data_wdata, a, esz, st, estb, ewd);
            end
        end

        for (int j = 0; j <= data_dly; j++) begin
            @(negedge clk);
            data_addr_ok = 1'b0;
            flush = (flush_at == 2 && j == 0);
            data_data_ok = (j == data_dly);
            data_rdata = (j == data_dly) ? rd : $urandom;
            #1;
            total++;
            if (data_req !== 1'b0 || mem_stall !== 1'b1 || load_valid !== 1'b0) begin
                bad++;
                $display("FAIL %s wait%0d: req=%b stall=%b lv=%b required req=0 stall=1 lv=0",
                         tag, j, data_req, mem_stall, load_valid);
            end
        end

        @(negedge clk);
        data_data_ok = 1'b0; flush = 1'b0; data_rdata = $urandom;
        if (flush_at != 0) begin
            wmem = 1'b0; load_type = 4'd0; store_type = 4'd0;
            #1;
            total++;
            if (load_valid !== 1'b0 || mem_stall !== 1'b0 || data_req !== 1'b0) begin
                bad++;
                $display("FAIL %s cancel_end: lv=%b stall=%b req=%b required 0 0 0",
                         tag, load_valid, mem_stall, data_req);
            end
            @(negedge clk);
            #1;
            total++;
            if (data_req !== 1'b0 || load_valid !== 1'b0 || mem_stall !== 1'b0) begin
                bad++;
                $display("FAIL %s cancel_idle: req=%b lv=%b stall=%b required 0 0 0",
                         tag, data_req, load_valid, mem_stall);
            end
        end else begin
            for (int h = 0; h <= hold; h++) begin
                if (h > 0) @(negedge clk);
                #1;
                total++;
                if (mem_stall !== 1'b0 || data_req !== 1'b0 || load_valid !== !st ||
                    (!st && load_result !== eres)) begin
                    bad++;
                    $display("FAIL %s done%0d: stall=%b req=%b lv=%b result=%h required stall=0 req=0 lv=%b result=%h",
                             tag, h, mem_stall, data_req, load_valid, load_result, !st, eres);
                end
            end
            if (end_flush) flush = 1'b1;
            else pipe_adv = 1'b1;
            wmem = 1'b0; load_type = 4'd0; store_type = 4'd0;
            if (!b2b) begin
                @(negedge clk);
                pipe_adv = 1'b0; flush = 1'b0;
                #1;
                total++;
                if (load_valid !== 1'b0 || data_req !== 1'b0 || mem_stall !== 1'b0) begin
                    bad++;
                    $display("FAIL %s leave_done: lv=%b req=%b stall=%b required 0 0 0",
                             tag, load_valid, data_req, mem_stall);
                end
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        total++;
        if (data_req !== 1'b0 || data_wr !== 1'b0 || data_size !== 2'd0 || data_addr !== 32'd0 ||
            data_wstrb !== 4'd0 || data_wdata !== 32'd0 || load_result !== 32'd0 ||
            load_valid !== 1'b0 || mem_stall !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: req=%b wr=%b size=%0d addr=%h strb=%b wdata=%h res=%h lv=%b stall=%b required all zero",
                     data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
                     load_result, load_valid, mem_stall);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_lb;
        run_txn(1'b0, 4'd4, 32'h0000_1003, 32'd0, 4'b1000, 32'h8011_2233, 0, 0, 0, 0, 1'b0, 1'b0, "lb_sign");
    endtask

    task automatic test_sh;
        run_txn(1'b1, 4'd2, 32'h0000_2002, 32'h0000_BEEF, 4'b1100, 32'd0, 0, 0, 0, 0, 1'b0, 1'b0, "sh_repl");
    endtask

    task automatic test_lhu_delay;
        run_txn(1'b0, 4'd3, 32'h0000_0010, 32'd0, 4'b0011, 32'h0000_F00D, 3, 0, 0, 2, 1'b0, 1'b0, "lhu_delay");
    endtask

    task automatic test_flush_wait;
        run_txn(1'b0, 4'd1, 32'h0000_0040, 32'd0, 4'b1111, 32'h1234_5678, 0, 2, 2, 0, 1'b0, 1'b0, "lw_flush_wait");
        run_txn(1'b0, 4'd5, 32'h0000_0041, 32'd0, 4'b0010, 32'h0000_AB00, 1, 1, 1, 0, 1'b0, 1'b0, "lbu_flush_req");
        run_txn(1'b0, 4'd2, 32'h0000_0042, 32'd0, 4'b1100, 32'h9ABC_0000, 0, 0, 0, 0, 1'b0, 1'b0, "lh_after_cancel");
    endtask

    task automatic test_flush_done;
        run_txn(1'b0, 4'd1, 32'h0000_0080, 32'd0, 4'b1111, 32'hDEAD_BEEF, 0, 1, 0, 1, 1'b1, 1'b0, "lw_flush_done");
    endtask

    task automatic test_exc_block;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            wmem = 1'b1; store_type = 4'd1; load_type = 4'd0; exc_block = 1'b1;
            addr = 32'h0000_0100; wdata = $urandom; byte_valid = 4'b1111;
            #1;
            total++;
            if (data_req !== 1'b0 || mem_stall !== 1'b0) begin
                bad++;
                $display("FAIL exc_block%0d: req=%b stall=%b required req=0 stall=0", c, data_req, mem_stall);
            end
        end
        @(negedge clk);
        wmem = 1'b0; store_type = 4'd0; exc_block = 1'b0;
        #1;
        total++;
        if (data_req !== 1'b0 || mem_stall !== 1'b0) begin
            bad++;
            $display("FAIL exc_block_after: req=%b stall=%b required req=0 stall=0", data_req, mem_stall);
        end
    endtask

    task automatic test_back_to_back;
        run_txn(1'b0, 4'd1, 32'h0000_0300, 32'd0, 4'b1111, 32'hCAFE_F00D, 0, 0, 0, 0, 1'b0, 1'b1, "b2b_lw");
        wmem = 1'b1; store_type = 4'd4; load_type = 4'd0;
        addr = 32'h0000_0305; wdata = 32'h0000_005A; byte_valid = 4'b0010;
        #1;
        total++;
        if (data_req !== 1'b0 || mem_stall !== 1'b0) begin
            bad++;
            $display("FAIL b2b_done_new: req=%b stall=%b required req=0 stall=0", data_req, mem_stall);
        end
        run_txn(1'b1, 4'd4, 32'h0000_0305, 32'h0000_005A, 4'b0010, 32'd0, 1, 0, 0, 0, 1'b0, 1'b0, "b2b_sb");
    endtask

    task automatic test_reset_in_wait;
        @(negedge clk);
        wmem = 1'b0; load_type = 4'd1; store_type = 4'd0; addr = 32'h0000_0504;
        byte_valid = 4'b1111;
        @(negedge clk);
        data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (data_req !== 1'b0 || data_wr !== 1'b0 || data_size !== 2'd0 || data_addr !== 32'd0 ||
            data_wstrb !== 4'd0 || data_wdata !== 32'd0 || load_result !== 32'd0 ||
            load_valid !== 1'b0 || mem_stall !== 1'b0) begin
            bad++;
            $display("FAIL reset_in_wait: req=%b wr=%b size=%0d addr=%h strb=%b wdata=%h res=%h lv=%b stall=%b required all zero",
                     data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
                     load_result, load_valid, mem_stall);
        end
        @(negedge clk);
        load_type = 4'd0;
        rst_n = 1'b1;
        @(negedge clk);
        data_data_ok = 1'b1; data_rdata = 32'h7777_7777;
        @(negedge clk);
        data_data_ok = 1'b0;
        #1;
        total++;
        if (load_valid !== 1'b0 || mem_stall !== 1'b0 || data_req !== 1'b0 || load_result !== 32'd0) begin
            bad++;
            $display("FAIL stale_response: lv=%b stall=%b req=%b res=%h required 0 0 0 0",
                     load_valid, mem_stall, data_req, load_result);
        end
        run_txn(1'b0, 4'd4, 32'h0000_0602, 32'd0, 4'b0100, 32'h0055_0000, 0, 0, 0, 0, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_random;
        logic [3:0] ltypes [5];
        logic [3:0] stypes [3];
        ltypes = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
        stypes = '{4'd1, 4'd2, 4'd4};
        for (int k = 0; k < 24; k++) begin
            bit st;
            logic [3:0] typ;
            int fsel;
            int fat;
            st   = 1'($urandom_range(0, 1));
            typ  = st ? stypes[$urandom_range(0, 2)] : ltypes[$urandom_range(0, 4)];
            fsel = $urandom_range(0, 7);
            fat  = (fsel == 0) ? 1 : (fsel == 1) ? 2 : 0;
            run_txn(st, typ, $urandom, $urandom, 4'($urandom_range(0, 15)), $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 3), fat, $urandom_range(0, 2),
                    ($urandom_range(0, 5) == 0), 1'b0, "random");
        end
    endtask

    initial begin
        test_reset;
        test_lb;
        test_sh;
        test_lhu_delay;
        test_flush_wait;
        test_flush_done;
        test_exc_block;
        test_back_to_back;
        test_reset_in_wait;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
